// File: rtl/neural_pkg.sv
// Shared constants and FSM state encoding for the neural MAC result collector.
package neural_pkg;

   localparam int          MAC_RESULT_ADDR_DFLT = 192;
   localparam logic [31:0] FP32_NEG_INF         = 32'hFF80_0000;
   localparam logic [31:0] FP32_POS_ZERO        = 32'h0000_0000;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_READY,
      READ,
      UPDATE,
      DONE
   } collector_state_e;

endpackage

// File: rtl/fp32_gt.sv
// Combinational IEEE-754 single-precision strict greater-than (a > b).
// NaN on either side yields 0; +0 and -0 compare equal.
module fp32_gt (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        gt
);

   logic a_nan;
   logic b_nan;
   logic both_zero;

   always_comb begin
      a_nan     = (&a[30:23]) && (|a[22:0]);
      b_nan     = (&b[30:23]) && (|b[22:0]);
      both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
      if (a_nan || b_nan || both_zero) begin
         gt = 1'b0;
      end else if (a[31] != b[31]) begin
         gt = ~a[31];
      end else if (!a[31]) begin
         gt = (a[30:0] > b[30:0]);
      end else begin
         // both negative: smaller magnitude is the larger number
         gt = (a[30:0] < b[30:0]);
      end
   end

endmodule

// File: rtl/neural_mac_result_collector.sv
// Avalon-MM master that reads one MAC result per output neuron, stores the
// scores and tracks a running fp32 argmax. Optional: NEURAL_COLLECTOR_RELU_EN.
//
// state      | meaning
// IDLE       | after reset, no inference started
// WAIT_READY | waiting for neuron_ready of neuron cnt
// READ       | Avalon read of the MAC result in flight
// UPDATE     | store score[cnt], update argmax
// DONE       | all scores collected, results held
module neural_mac_result_collector
   import neural_pkg::*;
#(
   parameter int                NUM_CLASSES     = 10,
   parameter int                IDX_W           = 4,
   parameter int                ADDR_W          = 11,
   parameter logic [ADDR_W-1:0] MAC_RESULT_ADDR = ADDR_W'(MAC_RESULT_ADDR_DFLT)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              neuron_ready,
   output logic [ADDR_W-1:0] m_address,
   output logic              m_read,
   input  logic [31:0]       m_readdata,
   input  logic              m_waitrequest,
   output logic              busy,
   output logic              done,
   output logic [IDX_W-1:0]  argmax_idx,
   output logic [31:0]       max_value,
   output logic              seq_err,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [31:0]       rd_data
);

   collector_state_e state_q, state_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] argmax_q, argmax_d;
   logic [31:0]      max_q, max_d;
   logic [31:0]      cap_q, cap_d;
   logic             seq_err_q, seq_err_d;
   logic             restart_q, restart_d;
   logic [31:0]      score_q [NUM_CLASSES];
   logic [31:0]      rd_data_q;
   logic             score_we;
   logic             reinit;
   logic             cap_gt;
   logic [31:0]      rd_val;

`ifdef NEURAL_COLLECTOR_RELU_EN
   assign rd_val = m_readdata[31] ? FP32_POS_ZERO : m_readdata;
`else
   assign rd_val = m_readdata;
`endif

   fp32_gt u_gt (
      .a  (cap_q),
      .b  (max_q),
      .gt (cap_gt)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      argmax_d  = argmax_q;
      max_d     = max_q;
      cap_d     = cap_q;
      seq_err_d = seq_err_q;
      restart_d = restart_q;
      score_we  = 1'b0;
      reinit    = 1'b0;

      unique case (state_q)
         IDLE, DONE: begin
            if (start)             reinit    = 1'b1;
            else if (neuron_ready) seq_err_d = 1'b1;
         end
         WAIT_READY: begin
            if (start)             reinit  = 1'b1;
            else if (neuron_ready) state_d = READ;
         end
         READ: begin
            if (neuron_ready && !start) seq_err_d = 1'b1;
            if (start)                  restart_d = 1'b1;
            // a read may not be abandoned: the MAC clears on acceptance
            if (!m_waitrequest) begin
               if (restart_q || start) begin
                  reinit = 1'b1;
               end else begin
                  cap_d   = rd_val;
                  state_d = UPDATE;
               end
            end
         end
         UPDATE: begin
            if (start) begin
               reinit = 1'b1;
            end else begin
               if (neuron_ready) seq_err_d = 1'b1;
               score_we = 1'b1;
               if ((cnt_q == '0) || cap_gt) begin
                  max_d    = cap_q;
                  argmax_d = cnt_q;
               end
               if (cnt_q == IDX_W'(NUM_CLASSES - 1)) begin
                  state_d = DONE;
               end else begin
                  cnt_d   = cnt_q + 1'b1;
                  state_d = WAIT_READY;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (reinit) begin
         state_d   = WAIT_READY;
         cnt_d     = '0;
         argmax_d  = '0;
         max_d     = FP32_NEG_INF;
         seq_err_d = 1'b0;
         restart_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         argmax_q  <= '0;
         max_q     <= FP32_NEG_INF;
         cap_q     <= '0;
         seq_err_q <= 1'b0;
         restart_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         argmax_q  <= argmax_d;
         max_q     <= max_d;
         cap_q     <= cap_d;
         seq_err_q <= seq_err_d;
         restart_q <= restart_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CLASSES; i++) score_q[i] <= '0;
         rd_data_q <= '0;
      end else begin
         if (score_we) score_q[cnt_q] <= cap_q;
         if ({1'b0, rd_idx} < (IDX_W+1)'(NUM_CLASSES)) rd_data_q <= score_q[rd_idx];
         else                                           rd_data_q <= '0;
      end
   end

   assign m_address  = MAC_RESULT_ADDR;
   assign m_read     = (state_q == READ);
   assign busy       = (state_q != IDLE) && (state_q != DONE);
   assign done       = (state_q == DONE);
   assign argmax_idx = argmax_q;
   assign max_value  = max_q;
   assign seq_err    = seq_err_q;
   assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_neural_mac_result_collector.sv
// Self-checking bench for neural_mac_result_collector: directed scenarios plus
// randomized inferences against a real-arithmetic argmax model.
module tb_neural_mac_result_collector;

   localparam int N      = 10;
   localparam int IDX_W  = 4;
   localparam int ADDR_W = 11;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              neuron_ready;
   logic [ADDR_W-1:0] m_address;
   logic              m_read;
   logic [31:0]       m_readdata;
   logic              m_waitrequest;
   logic              busy;
   logic              done;
   logic [IDX_W-1:0]  argmax_idx;
   logic [31:0]       max_value;
   logic              seq_err;
   logic [IDX_W-1:0]  rd_idx;
   logic [31:0]       rd_data;

   int          vectors    = 0;
   int          miscompares = 0;
   int          acc_reads  = 0;
   logic [31:0] sc [N];
   int          st [N];

   neural_mac_result_collector dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .neuron_ready  (neuron_ready),
      .m_address     (m_address),
      .m_read        (m_read),
      .m_readdata    (m_readdata),
      .m_waitrequest (m_waitrequest),
      .busy          (busy),
      .done          (done),
      .argmax_idx    (argmax_idx),
      .max_value     (max_value),
      .seq_err       (seq_err),
      .rd_idx        (rd_idx),
      .rd_data       (rd_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (m_read && !m_waitrequest) acc_reads <= acc_reads + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] eff(input logic [31:0] v);
`ifdef NEURAL_COLLECTOR_RELU_EN
      return v[31] ? 32'h0 : v;
`else
      return v;
`endif
   endfunction

   function automatic bit is_nan(input logic [31:0] v);
      return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
   endfunction

   function automatic real fp2real(input logic [31:0] v);
      int  e;
      real m, r;
      e = int'(v[30:23]);
      m = real'(v[22:0]);
      if (e == 0) r = m * (2.0 ** (-149.0));
      else        r = (1.0 + m / 8388608.0) * (2.0 ** real'(e - 127));
      return v[31] ? -r : r;
   endfunction

   // First score always taken; later ones only when strictly larger and
   // neither side is NaN. Ties keep the earlier index.
   task automatic model(output int idx, output logic [31:0] mx);
      idx = 0;
      for (int i = 1; i < N; i++) begin
         if (!is_nan(eff(sc[i])) && !is_nan(eff(sc[idx])) &&
             (fp2real(eff(sc[i])) > fp2real(eff(sc[idx]))))
            idx = i;
      end
      mx = eff(sc[idx]);
   endtask

   function automatic logic [31:0] rnd_fp();
      logic [31:0] r;
      int          k;
      r = $urandom();
      k = $urandom_range(0, 9);
      if (k == 0) return {r[31], 8'hFF, 1'b1, r[21:0]};
      if (k == 1) return {r[31], 31'h0};
      return {r[31], 8'(120 + $urandom_range(0, 15)), r[22:0]};
   endfunction

   task automatic fill_random();
      for (int i = 0; i < N; i++) begin
         if (i > 0 && $urandom_range(0, 5) == 0) sc[i] = sc[i-1];
         else                                    sc[i] = rnd_fp();
         st[i] = $urandom_range(0, 3);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic do_neuron(input logic [31:0] v, input int stall);
      @(negedge clk) neuron_ready = 1'b1;
      @(negedge clk) neuron_ready = 1'b0;
      chk("m_read_rise", m_read, 1);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk("m_read_stall", m_read, 1);
         chk("addr_stall", m_address, 192);
      end
      m_waitrequest = 1'b0;
      m_readdata    = v;
      @(negedge clk);
      m_waitrequest = 1'b1;
      m_readdata    = $urandom();
      chk("m_read_drop", m_read, 0);
      @(negedge clk);
   endtask

   task automatic readback(input int idx, input logic [31:0] exp);
      @(negedge clk) rd_idx = IDX_W'(idx);
      @(negedge clk);
      chk($sformatf("score[%0d]", idx), rd_data, exp);
   endtask

   task automatic run_inf();
      pulse_start();
      for (int i = 0; i < N; i++) do_neuron(sc[i], st[i]);
   endtask

   task automatic check_results(input string tag);
      int          idx;
      logic [31:0] mx;
      model(idx, mx);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_argmax"}, argmax_idx, idx);
      chk({tag, "_max"}, max_value, mx);
      for (int i = 0; i < N; i++) readback(i, eff(sc[i]));
   endtask

   initial begin
      int          r0;
      logic [31:0] mx_snap;
      logic [IDX_W-1:0] idx_snap;

      reset = 1'b1; start = 1'b0; neuron_ready = 1'b0;
      m_waitrequest = 1'b1; m_readdata = '0; rd_idx = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_seq_err", seq_err, 0);
      chk("rst_m_read", m_read, 0);
      chk("rst_argmax", argmax_idx, 0);
      chk("rst_max", max_value, 32'hFF800000);
      chk("rst_addr", m_address, 192);
      chk("rst_rd_data", rd_data, 0);
      reset = 1'b0;
      @(negedge clk);

      // basic 1.0..10.0 with a 5-cycle stall on neuron 2
      sc = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
             32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000};
      for (int i = 0; i < N; i++) st[i] = (i == 2) ? 5 : 0;
      r0 = acc_reads;
      run_inf();
      chk("basic_reads", acc_reads - r0, N);
      chk("basic_argmax", argmax_idx, 9);
      chk("basic_max", max_value, 32'h41200000);
      readback(3, 32'h40800000);
      readback(2, 32'h40400000);
      check_results("basic");

      // negatives, tie and NaN
      sc = '{32'hC0400000, 32'hBF800000, 32'hBF800000, 32'h7FC00000, 32'hC0000000,
             32'hC0000000, 32'hC0000000, 32'hC0000000, 32'hC0000000, 32'hC0000000};
      for (int i = 0; i < N; i++) st[i] = 0;
      run_inf();
`ifdef NEURAL_COLLECTOR_RELU_EN
      chk("neg_argmax", argmax_idx, 0);
      chk("neg_max", max_value, 32'h00000000);
      readback(0, 32'h0);
      readback(1, 32'h0);
      readback(2, 32'h0);
`else
      chk("neg_argmax", argmax_idx, 1);
      chk("neg_max", max_value, 32'hBF800000);
`endif
      check_results("neg");

      // simultaneous start and neuron_ready: start wins
      @(negedge clk) begin start = 1'b1; neuron_ready = 1'b1; end
      @(negedge clk) begin start = 1'b0; neuron_ready = 1'b0; end
      chk("sim_seq_err", seq_err, 0);
      chk("sim_busy", busy, 1);
      chk("sim_m_read", m_read, 0);
      chk("sim_max", max_value, 32'hFF800000);

      // neuron_ready during READ
      r0 = acc_reads;
      @(negedge clk) neuron_ready = 1'b1;
      @(negedge clk) neuron_ready = 1'b1;
      @(negedge clk) neuron_ready = 1'b0;
      chk("rd_seq_err", seq_err, 1);
      chk("rd_m_read", m_read, 1);
      m_waitrequest = 1'b0; m_readdata = 32'h40000000;
      @(negedge clk) m_waitrequest = 1'b1;
      @(negedge clk);
      chk("rd_one_read", acc_reads - r0, 1);
      @(negedge clk);
      chk("rd_no_extra", m_read, 0);
      pulse_start();
      chk("restart_seq_clr", seq_err, 0);
      chk("restart_max", max_value, 32'hFF800000);

      // neuron_ready in DONE
      fill_random();
      run_inf();
      check_results("rand0");
      mx_snap = max_value; idx_snap = argmax_idx;
      @(negedge clk) neuron_ready = 1'b1;
      @(negedge clk) neuron_ready = 1'b0;
      chk("done_seq_err", seq_err, 1);
      chk("done_held", done, 1);
      chk("done_max", max_value, mx_snap);
      chk("done_argmax", argmax_idx, idx_snap);

      for (int k = 1; k <= 3; k++) begin
         fill_random();
         run_inf();
         check_results($sformatf("rand%0d", k));
      end

      // start during a stalled READ
      fill_random();
      pulse_start();
      do_neuron(sc[0], 0);
      r0 = acc_reads;
      @(negedge clk) neuron_ready = 1'b1;
      @(negedge clk) neuron_ready = 1'b0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      chk("rs_m_read_held", m_read, 1);
      chk("rs_busy", busy, 1);
      @(negedge clk);
      chk("rs_m_read_held2", m_read, 1);
      m_waitrequest = 1'b0; m_readdata = 32'h7F000000;
      @(negedge clk) m_waitrequest = 1'b1;
      chk("rs_one_read", acc_reads - r0, 1);
      chk("rs_m_read_drop", m_read, 0);
      chk("rs_max", max_value, 32'hFF800000);
      chk("rs_argmax", argmax_idx, 0);
      chk("rs_done", done, 0);
      chk("rs_seq_err", seq_err, 0);
      for (int i = 0; i < N; i++) begin
         do_neuron(sc[i], st[i]);
         if (i == N - 2) chk("rs_not_done_early", done, 0);
      end
      check_results("rs");

      // asynchronous reset mid-READ
      pulse_start();
      @(negedge clk) neuron_ready = 1'b1;
      @(negedge clk) neuron_ready = 1'b0;
      chk("ar_m_read_pre", m_read, 1);
      #2 reset = 1'b1;
      #1;
      chk("ar_m_read", m_read, 0);
      chk("ar_busy", busy, 0);
      chk("ar_done", done, 0);
      chk("ar_max", max_value, 32'hFF800000);
      chk("ar_argmax", argmax_idx, 0);
      chk("ar_seq_err", seq_err, 0);
      chk("ar_rd_data", rd_data, 0);
      @(negedge clk) reset = 1'b0;
      readback(0, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
